// File: rtl/reg_wb_sched_pkg.sv
// Core-wide constants and types shared by the register writeback scheduler.
// The writeback source enum doubles as the round-robin "last granted" pointer.
package reg_wb_sched_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = $clog2(NREG);

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_LSU = 1'b1
    } wb_src_e;

    localparam logic [AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/reg_wb_sched_arb.sv
// Two-way round-robin arbiter for the writeback port.
// Bit 0 is the ALU and bit 1 the LSU; on a tie the source not granted most recently wins.
module wb_rr_arb
    import reg_wb_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    wb_src_e last_reg;
    wb_src_e last_next;

    // Grants are suppressed while reset is high so requesters never see a
    // handshake that the discarded pipeline would lose.
    always_comb begin
        grant     = 2'b00;
        last_next = last_reg;
        if (!rst) begin
            if (valid == 2'b11) begin
                grant = (last_reg == WB_SRC_ALU) ? 2'b10 : 2'b01;
            end else begin
                grant = valid;
            end
        end
        if (grant[0]) begin
            last_next = WB_SRC_ALU;
        end else if (grant[1]) begin
            last_next = WB_SRC_LSU;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_reg <= WB_SRC_LSU;
        end else begin
            last_reg <= last_next;
        end
    end

endmodule

// File: rtl/reg_wb_sched.sv
// Register scoreboard plus writeback scheduler: stalls issue on RAW/WAW hazards and
// funnels ALU/LSU writebacks through one registered stage onto the register file write port.
module reg_wb_sched
    import reg_wb_sched_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rs1,
    input  logic [AW-1:0]   issue_rs2,
    input  logic [AW-1:0]   issue_rd,
    input  logic            issue_uses_rd,
    output logic            issue_stall,
    input  logic            alu_wb_valid,
    input  logic [AW-1:0]   alu_wb_addr,
    input  logic [XLEN-1:0] alu_wb_data,
    output logic            alu_wb_ready,
    input  logic            lsu_wb_valid,
    input  logic [AW-1:0]   lsu_wb_addr,
    input  logic [XLEN-1:0] lsu_wb_data,
    output logic            lsu_wb_ready,
    output logic            rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [NREG-1:0] busy_vec,
    output logic            sb_err
);

    logic [NREG-1:0] busy_reg;
    logic [NREG-1:0] busy_next;
    logic            rf_we_reg;
    logic [AW-1:0]   rf_waddr_reg;
    logic [XLEN-1:0] rf_wdata_reg;
    logic            sb_err_reg;

    logic            issue_accept;
    logic [1:0]      wb_grant;
    logic            wb_any;
    logic [AW-1:0]   wb_addr_sel;
    logic [XLEN-1:0] wb_data_sel;
    logic            wb_writes;
    logic            wb_err_hit;

    // Hazard check looks only at registered busy bits; a same-cycle clear does not release it.
    assign issue_stall  = issue_valid & (busy_reg[issue_rs1] | busy_reg[issue_rs2] |
                                         (issue_uses_rd & busy_reg[issue_rd]));
    assign issue_accept = issue_valid & ~issue_stall & issue_uses_rd & (issue_rd != REG_ZERO);

    wb_rr_arb u_arb (
        .clk   (clk),
        .rst   (rst),
        .valid ({lsu_wb_valid, alu_wb_valid}),
        .grant (wb_grant)
    );

    assign alu_wb_ready = wb_grant[WB_SRC_ALU];
    assign lsu_wb_ready = wb_grant[WB_SRC_LSU];
    assign wb_any       = |wb_grant;
    assign wb_addr_sel  = wb_grant[WB_SRC_LSU] ? lsu_wb_addr : alu_wb_addr;
    assign wb_data_sel  = wb_grant[WB_SRC_LSU] ? lsu_wb_data : alu_wb_data;
    assign wb_writes    = wb_any & (wb_addr_sel != REG_ZERO);
    assign wb_err_hit   = wb_writes & ~busy_reg[wb_addr_sel];

    // Per-register next state: a new issue (set) takes precedence over the registered write (clear).
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign busy_next[gi] = 1'b0;
            end else begin : g_reg
                assign busy_next[gi] =
                    (issue_accept && (issue_rd == AW'(gi))) ||
                    (busy_reg[gi] && !(rf_we_reg && (rf_waddr_reg == AW'(gi))));
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg     <= '0;
            rf_we_reg    <= 1'b0;
            rf_waddr_reg <= '0;
            rf_wdata_reg <= '0;
            sb_err_reg   <= 1'b0;
        end else begin
            busy_reg  <= busy_next;
            rf_we_reg <= wb_writes;
            // Address/data only move on a real write so they hold while rf_we is low.
            if (wb_writes) begin
                rf_waddr_reg <= wb_addr_sel;
                rf_wdata_reg <= wb_data_sel;
            end
            if (wb_err_hit) begin
                sb_err_reg <= 1'b1;
            end
        end
    end

    assign rf_we    = rf_we_reg;
    assign rf_waddr = rf_waddr_reg;
    assign rf_wdata = rf_wdata_reg;
    assign busy_vec = busy_reg;
    assign sb_err   = sb_err_reg;

endmodule

// File: doc/reg_wb_sched.md
Name: reg_wb_sched

Overview:
- Scoreboard and write-port scheduler for the 32x32 integer register file.
- Tracks destination registers with writes in flight and stalls issue on RAW/WAW hazards.
- Arbitrates two writeback requesters (ALU, LSU) onto the register file's single write port, round-robin.
- Drives the register file write port (write enable, write address, write data) through one register stage.

Parameters:
- XLEN, 32, data width of register and writeback data
- NREG, 32, number of architectural registers; x0 hard-wired zero
- AW, 5, register address width, equal to log2(NREG)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- issue_valid  in  1  decode presents an instruction this cycle
- issue_rs1  in  AW  source register 1 address
- issue_rs2  in  AW  source register 2 address
- issue_rd  in  AW  destination register address
- issue_uses_rd  in  1  instruction will write issue_rd
- issue_stall  out  1  hazard: issue must hold this cycle (combinational)
- alu_wb_valid  in  1  ALU writeback request
- alu_wb_addr  in  AW  ALU writeback register
- alu_wb_data  in  XLEN  ALU writeback data
- alu_wb_ready  out  1  ALU request accepted this cycle (combinational)
- lsu_wb_valid  in  1  LSU writeback request
- lsu_wb_addr  in  AW  LSU writeback register
- lsu_wb_data  in  XLEN  LSU writeback data
- lsu_wb_ready  out  1  LSU request accepted this cycle (combinational)
- rf_we  out  1  register file write enable
- rf_waddr  out  AW  register file write address
- rf_wdata  out  XLEN  register file write data
- busy_vec  out  NREG  scoreboard bits; bit 0 always 0
- sb_err  out  1  sticky flag: writeback to a register that is not busy

Behaviour:
- Reset (sync, rst=1 at posedge):
  - busy_vec=0, rf_we=0, rf_waddr=0, rf_wdata=0, sb_err=0.
  - Round-robin pointer set so the ALU wins the first tie.
  - rst has priority over all other inputs.
- Hazard check:
  - issue_stall = issue_valid & (busy[rs1] | busy[rs2] | (issue_uses_rd & busy[rd])).
  - busy[0] is constant 0, so x0 never stalls.
  - The check uses registered busy_vec only; a clear happening in the same cycle does not release the stall.
- Issue:
  - An accepted issue is issue_valid & ~issue_stall & issue_uses_rd & rd!=0.
  - It sets busy[rd] at the next edge.
  - Set and clear of the same index in one cycle cannot occur: the rd stall prevents it.
  - If it occurs anyway, set wins.
- Arbitration:
  - If only one requester is valid, that requester is granted.
  - If both are valid, the requester not granted most recently is granted.
  - The pointer updates on every grant.
  - The grant appears on *_wb_ready in the same cycle; at most one ready is high per cycle.
  - A requester holds valid, addr and data stable until ready; the bench flags any violation.
- Write path, for a grant in cycle N:
  - In cycle N+1: rf_we=1 if addr!=0; rf_waddr and rf_wdata are the granted values.
  - rf_we=0 in any cycle following a cycle with no grant. rf_waddr and rf_wdata hold their previous values when rf_we=0.
- Scoreboard clear:
  - busy[rf_waddr] clears at the edge ending the cycle where rf_we=1, i.e. end of N+1.
  - A dependent instruction can therefore issue no earlier than N+2.
- Error flag:
  - A granted writeback with addr!=0 whose busy bit is 0 in grant cycle N sets sb_err at the end of N.
  - The write still proceeds. sb_err is cleared only by rst.
- x0 writeback: accepted (ready=1), no rf_we, no scoreboard effect, no error.
- Throughput: one writeback per cycle sustained; with both requesters continuously valid, grants alternate ALU, LSU, ALU, ...
- Reset mid-operation:
  - All in-flight state is discarded, including a registered rf_we.
  - Requesters see ready=0 during the rst cycle.

Decomposition:
- Shared package (core-wide) holds:
  - XLEN, NREG, AW.
  - Writeback source enum WB_SRC_ALU=0, WB_SRC_LSU=1, used for the round-robin pointer.
  - REG_ZERO constant.
- One natural sub-module, wb_rr_arb:
  - 2-way round-robin arbiter; inputs valid[1:0], clk and rst; outputs grant[1:0].
  - Scoreboard and write register stay in the top module.

Test Plan:
1. Reset then idle:
   - Required: busy_vec=0, rf_we=0, sb_err=0.
   - Issue rs1=3 rs2=4 rd=5 with uses_rd=1 → issue_stall=0, and busy_vec=0x0000_0020 next cycle.
2. RAW stall:
   - Setup: busy[5]=1; issue rs1=5 → issue_stall=1.
   - ALU writes back x5=0xDEADBEEF in cycle N → rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF in N+1.
   - Required: stall=1 through N+1, stall=0 in N+2.
3. Contention:
   - Setup: busy[6] and busy[7] set; ALU (x6=0x11) and LSU (x7=0x22) both valid in cycle N.
   - Cycle N → alu_wb_ready=1, lsu_wb_ready=0.
   - Cycle N+1 → lsu_wb_ready=1; rf writes x6 in N+1 and x7 in N+2.
   - Required: both busy bits clear by N+3.
4. Sustained contention, 8 cycles, both valid → grants alternate ALU, LSU, ALU, ... with exactly 4 grants each.
5. Boundary cases:
   - Issue rd=0 with uses_rd=1 → no busy bit set.
   - LSU writeback to x0 → lsu_wb_ready=1, rf_we=0.
   - Writeback to non-busy x9 → sb_err=1 and it stays 1 until rst.
6. Reset mid-flight:
   - Setup: busy[10]=1, ALU grant in cycle N, rst asserted in N+1.
   - Required: rf_we=0 after rst, busy_vec=0, and the ALU wins the next tie.
